// File: rtl/frogger_pkg.sv
// River geometry, ride FSM states and coordinate/speed types shared by the
// frog river-ride logic.
package frogger_pkg;

    localparam int BLOCKSIZE      = 32;
    localparam int X_OFFSET_LEFT  = 96;
    localparam int X_OFFSET_RIGHT = 544;
    localparam int NUM_LANES      = 6;

    typedef logic        [9:0] coord_t;
    typedef logic signed [9:0] speed_t;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RIDING,
        DROWNING,
        DONE
    } ride_state_t;

endpackage

// File: rtl/log_hit_check.sv
// Combinational test of whether the frog centre lies on either of two logs
// sharing one length; sums are 11 bits so logs near x=1023 do not wrap.
module log_hit_check
    import frogger_pkg::*;
(
    input  logic [10:0] fc,
    input  coord_t      log0_x,
    input  coord_t      log1_x,
    input  coord_t      len,
    output logic        hit
);

    logic [10:0] w_end0;
    logic [10:0] w_end1;
    logic        w_hit0;
    logic        w_hit1;

    assign w_end0 = {1'b0, log0_x} + {1'b0, len};
    assign w_end1 = {1'b0, log1_x} + {1'b0, len};
    assign w_hit0 = ({1'b0, log0_x} <= fc) && (fc < w_end0);
    assign w_hit1 = ({1'b0, log1_x} <= fc) && (fc < w_end1);
    assign hit    = w_hit0 || w_hit1;

endmodule

// File: rtl/frog_river_ride.sv
// Frog-on-log ride tracker: emits carry deltas while riding and runs the drown
// sequence. Define FROG_DROWN_ANIM_EN for the multi-cycle drowning animation.
module frog_river_ride
    import frogger_pkg::*;
#(
    parameter int BLOCKSIZE      = frogger_pkg::BLOCKSIZE,
    parameter int X_OFFSET_LEFT  = frogger_pkg::X_OFFSET_LEFT,
    parameter int X_OFFSET_RIGHT = frogger_pkg::X_OFFSET_RIGHT,
    parameter int NUM_LANES      = frogger_pkg::NUM_LANES,
    parameter int GRACE_CYCLES   = 4
`ifdef FROG_DROWN_ANIM_EN
    , parameter logic [23:0] DROWN_CYCLES = 24'd3000000
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  coord_t                   frog_x,
    input  logic                     frog_in_river,
    input  logic [2:0]               frog_lane,
    input  coord_t [NUM_LANES-1:0]   log0_x,
    input  coord_t [NUM_LANES-1:0]   log1_x,
    input  speed_t [NUM_LANES-1:0]   log_speed,
    input  coord_t [NUM_LANES-1:0]   log_len,
    input  logic                     respawn_ack,
    output speed_t                   carry_dx,
    output logic                     carry_valid,
    output logic                     riding,
    output logic                     drowning,
    output logic                     drown_pulse,
    output logic [1:0]               drown_frame
);

    localparam logic signed [11:0] EDGE_LO    = 12'(X_OFFSET_LEFT);
    localparam logic signed [11:0] EDGE_HI    = 12'(X_OFFSET_RIGHT - BLOCKSIZE);
    localparam logic        [10:0] HALF_W     = 11'(BLOCKSIZE / 2);
    localparam logic        [7:0]  GRACE_LOAD = 8'(GRACE_CYCLES);

    ride_state_t        r_state;
    ride_state_t        w_state_next;
    logic [7:0]         r_grace;
    logic [7:0]         w_grace_next;
    logic               r_on_log;
    logic [2:0]         r_lane;
    logic               r_carry_valid;
    logic               w_carry_valid_next;
    speed_t             r_carry_dx;
    speed_t             w_carry_dx_next;

    logic [10:0]        w_fc;
    logic               w_lane_ok;
    logic [2:0]         w_lane_idx;
    logic               w_hit_raw;
    logic               w_hit;
    speed_t             w_speed;
    logic signed [11:0] w_next_x;
    logic               w_swept;
    logic               w_lane_chg;
    logic               w_drown_done;

    assign w_fc       = {1'b0, frog_x} + HALF_W;
    assign w_lane_ok  = int'(frog_lane) < NUM_LANES;
    assign w_lane_idx = w_lane_ok ? frog_lane : '0;
    assign w_speed    = w_lane_ok ? log_speed[w_lane_idx] : '0;
    assign w_hit      = w_lane_ok && w_hit_raw;
    assign w_lane_chg = (frog_lane != r_lane);

    log_hit_check u_hit (
        .fc     (w_fc),
        .log0_x (log0_x[w_lane_idx]),
        .log1_x (log1_x[w_lane_idx]),
        .len    (log_len[w_lane_idx]),
        .hit    (w_hit_raw)
    );

    // Edge test uses the position the frog would reach after this carry.
    assign w_next_x = $signed({2'b00, frog_x}) + $signed({{2{w_speed[9]}}, w_speed});
    assign w_swept  = (w_next_x < EDGE_LO) || (w_next_x > EDGE_HI);

`ifdef FROG_DROWN_ANIM_EN
    localparam logic [23:0] FRAME_LEN = DROWN_CYCLES >> 2;

    logic [23:0] r_drown_cnt;
    logic [23:0] r_frame_cnt;
    logic [1:0]  r_frame;

    assign w_drown_done = (r_drown_cnt == DROWN_CYCLES - 24'd1);
    assign drown_frame  = r_frame;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drown_cnt <= '0;
            r_frame_cnt <= '0;
            r_frame     <= '0;
        end else if (r_state == DROWNING) begin
            r_drown_cnt <= r_drown_cnt + 24'd1;
            if (r_frame_cnt == FRAME_LEN - 24'd1) begin
                r_frame_cnt <= '0;
                if (r_frame != 2'd3) begin
                    r_frame <= r_frame + 2'd1;
                end
            end else begin
                r_frame_cnt <= r_frame_cnt + 24'd1;
            end
        end else begin
            r_drown_cnt <= '0;
            r_frame_cnt <= '0;
            r_frame     <= (r_state == DONE) ? 2'd3 : 2'd0;
        end
    end
`else
    assign w_drown_done = 1'b1;
    assign drown_frame  = '0;
`endif

    always_comb begin
        w_state_next       = r_state;
        w_grace_next       = r_grace;
        w_carry_valid_next = 1'b0;
        w_carry_dx_next    = '0;
        unique case (r_state)
            IDLE: begin
                if (frog_in_river) begin
                    w_state_next = SETTLE;
                    w_grace_next = GRACE_LOAD;
                end
            end
            SETTLE: begin
                if (!frog_in_river) begin
                    w_state_next = IDLE;
                end else if (w_lane_chg) begin
                    w_grace_next = GRACE_LOAD;
                end else if (r_grace <= 8'd1) begin
                    w_grace_next = '0;
                    w_state_next = r_on_log ? RIDING : DROWNING;
                end else begin
                    w_grace_next = r_grace - 8'd1;
                end
            end
            RIDING: begin
                if (!frog_in_river) begin
                    w_state_next = IDLE;
                end else if (w_lane_chg) begin
                    w_state_next = SETTLE;
                    w_grace_next = GRACE_LOAD;
                end else if (!r_on_log) begin
                    w_state_next = DROWNING;
                end else if (w_speed != '0) begin
                    if (w_swept) begin
                        w_state_next = DROWNING;
                    end else begin
                        w_carry_valid_next = 1'b1;
                        w_carry_dx_next    = w_speed;
                    end
                end
            end
            DROWNING: begin
                if (w_drown_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (respawn_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grace       <= '0;
            r_on_log      <= 1'b0;
            r_lane        <= '0;
            r_carry_valid <= 1'b0;
            r_carry_dx    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_grace       <= w_grace_next;
            r_on_log      <= w_hit;
            r_lane        <= frog_lane;
            r_carry_valid <= w_carry_valid_next;
            r_carry_dx    <= w_carry_dx_next;
        end
    end

    assign carry_valid = r_carry_valid;
    assign carry_dx    = r_carry_dx;
    assign riding      = (r_state == RIDING);
    assign drowning    = (r_state == DROWNING);
    assign drown_pulse = (r_state == DONE);

endmodule
